// File: rtl/tick_pkg.sv
// Shared defaults for the divider-tap tick counter.
// Holds bus/counter sizing and the counter operation encoding.
package tick_pkg;

    localparam int DEF_DIV_W   = 32;
    localparam int DEF_CNT_W   = 4;
    localparam int DEF_MODULUS = 10;

    // Narrowest tap select able to address every bit of the divider bus
    function automatic int sel_width(input int div_w);
        return (div_w > 1) ? $clog2(div_w) : 1;
    endfunction

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_INC  = 2'd2,
        OP_DEC  = 2'd3
    } cnt_op_t;

endpackage

// File: rtl/tap_edge_det.sv
// Tap mux plus rising-edge detector on the selected clk_div bit.
// Produces a registered one-cycle tick in the clk domain.
module tap_edge_det
    import tick_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W,
    parameter int SEL_W = sel_width(DIV_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] clk_div,
    input  logic [SEL_W-1:0] tap_sel,
    output logic             tick
);

    logic             tap_bit;
    logic             tap_q;
    logic [SEL_W-1:0] sel_q;
    logic             primed;

    // Out-of-range selects fall back to the slowest tap
    always_comb begin
        tap_bit = clk_div[DIV_W-1];
        if (32'(tap_sel) < DIV_W) begin
            tap_bit = clk_div[tap_sel];
        end
    end

    // Tap history, select history and edge pulse; a select change masks the edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tap_q  <= 1'b0;
            sel_q  <= '0;
            primed <= 1'b0;
            tick   <= 1'b0;
        end else begin
            tap_q  <= tap_bit;
            sel_q  <= tap_sel;
            primed <= 1'b1;
            tick   <= primed & (sel_q == tap_sel) & tap_bit & ~tap_q;
        end
    end

endmodule

// File: rtl/div_tick_counter.sv
// Selects a clk_div tap and counts its rising edges modulo MODULUS.
// Loadable up/down counter with a one-cycle carry/borrow pulse.
module div_tick_counter
    import tick_pkg::*;
#(
    parameter int DIV_W   = DEF_DIV_W,
    parameter int SEL_W   = sel_width(DIV_W),
    parameter int CNT_W   = DEF_CNT_W,
    parameter int MODULUS = DEF_MODULUS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] clk_div,
    input  logic [SEL_W-1:0] tap_sel,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tick,
    output logic [CNT_W-1:0] cnt,
    output logic             co
);

    localparam logic [CNT_W-1:0] TOP = CNT_W'(MODULUS - 1);

    cnt_op_t          op;
    logic [CNT_W-1:0] cnt_nx;
    logic             co_nx;
    logic [CNT_W-1:0] load_cl;

    tap_edge_det #(
        .DIV_W (DIV_W),
        .SEL_W (SEL_W)
    ) u_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_div (clk_div),
        .tap_sel (tap_sel),
        .tick    (tick)
    );

    // Keep loaded values inside 0..MODULUS-1
    assign load_cl = (load_val > TOP) ? TOP : load_val;

    // Priority pick of the counter operation: load beats a tick
    always_comb begin
        op = OP_HOLD;
        if (load) begin
            op = OP_LOAD;
        end else if (tick && en) begin
            op = up ? OP_INC : OP_DEC;
        end
    end

    // Next count with explicit modulo wrap and carry/borrow
    always_comb begin
        cnt_nx = cnt;
        co_nx  = 1'b0;
        unique case (op)
            OP_LOAD: cnt_nx = load_cl;
            OP_INC: begin
                if (cnt == TOP) begin
                    cnt_nx = '0;
                    co_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            OP_DEC: begin
                if (cnt == '0) begin
                    cnt_nx = TOP;
                    co_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            default: cnt_nx = cnt;
        endcase
    end

    // Counter and carry/borrow registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            co  <= 1'b0;
        end else begin
            cnt <= cnt_nx;
            co  <= co_nx;
        end
    end

endmodule

// File: tb/tb_div_tick_counter.sv
// Directed bench for div_tick_counter with a cycle-level reference model.
// Literal checks pin key sequences; the model is checked every cycle.
module tb_div_tick_counter;

    localparam int DIV_W   = 32;
    localparam int SEL_W   = 5;
    localparam int CNT_W   = 4;
    localparam int MODULUS = 10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [DIV_W-1:0] clk_div;
    logic [SEL_W-1:0] tap_sel;
    logic             en;
    logic             up;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             tick;
    logic [CNT_W-1:0] cnt;
    logic             co;

    int nvec = 0;
    int nerr = 0;
    bit free = 1'b1;

    div_tick_counter #(
        .DIV_W   (DIV_W),
        .SEL_W   (SEL_W),
        .CNT_W   (CNT_W),
        .MODULUS (MODULUS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clk_div  (clk_div),
        .tap_sel  (tap_sel),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .tick     (tick),
        .cnt      (cnt),
        .co       (co)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic sel_bit(input logic [DIV_W-1:0] d,
                                     input logic [SEL_W-1:0] s);
        int idx;
        idx = (int'(s) >= DIV_W) ? DIV_W - 1 : int'(s);
        return d[idx];
    endfunction

    // Reference model: a tick is a 0->1 step of the same tap between
    // two consecutive out-of-reset cycles; the counter is plain mod-N math.
    int               m_cnt = 0;
    bit               m_co = 0;
    bit               m_tick = 0;
    bit               m_valid = 0;
    logic [DIV_W-1:0] p_div = '0;
    logic [SEL_W-1:0] p_sel = '0;
    bit               p_rst = 0;

    always @(posedge clk) begin
        bit b_now;
        bit b_prev;
        bit strobe;
        b_now  = sel_bit(clk_div, tap_sel);
        b_prev = sel_bit(p_div, tap_sel);
        if (!rst_n) begin
            m_cnt   = 0;
            m_co    = 0;
            m_tick  = 0;
            m_valid = 1;
        end else begin
            strobe = m_tick;
            if (load) begin
                m_cnt = (int'(load_val) > MODULUS - 1) ? MODULUS - 1
                                                       : int'(load_val);
                m_co  = 0;
            end else if (strobe && en && up) begin
                m_co  = (m_cnt == MODULUS - 1);
                m_cnt = (m_cnt + 1) % MODULUS;
            end else if (strobe && en) begin
                m_co  = (m_cnt == 0);
                m_cnt = (m_cnt + MODULUS - 1) % MODULUS;
            end else begin
                m_co = 0;
            end
            m_tick = p_rst && (tap_sel == p_sel) && b_now && !b_prev;
        end
        p_div = clk_div;
        p_sel = tap_sel;
        p_rst = rst_n;
        if (m_valid) begin
            #1;
            chk("model_tick", 32'(tick), 32'(m_tick));
            chk("model_cnt", 32'(cnt), 32'(m_cnt));
            chk("model_co", 32'(co), 32'(m_co));
        end
    end

    task automatic step();
        @(negedge clk);
        if (free) clk_div = clk_div + 1'b1;
    endtask

    task automatic wait_cnt(input string nm);
        logic [CNT_W-1:0] old;
        old = cnt;
        for (int i = 0; i < 8; i++) begin
            step();
            if (cnt != old) return;
        end
        nvec++;
        nerr++;
        $display("FAIL %s: timeout, cnt stuck at %0d", nm, cnt);
    endtask

    initial begin
        int seq1 [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
        int seq2 [3]  = '{9, 8, 7};
        int  nt;
        bit  any_co;
        bit  got;

        rst_n    = 1'b0;
        clk_div  = '0;
        tap_sel  = '0;
        en       = 1'b1;
        up       = 1'b1;
        load     = 1'b0;
        load_val = '0;
        step();
        step();
        chk("rst_tick", 32'(tick), 0);
        chk("rst_cnt", 32'(cnt), 0);
        chk("rst_co", 32'(co), 0);
        rst_n = 1'b1;

        // 1: count up 0..9,0 with carry on the wrap
        for (int i = 0; i < 10; i++) begin
            wait_cnt("t1_wait");
            chk("t1_cnt", 32'(cnt), 32'(seq1[i]));
            chk("t1_co", 32'(co), (i == 9) ? 1 : 0);
        end

        // 2: count down from 0 borrows to 9
        up = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_cnt("t2_wait");
            chk("t2_cnt", 32'(cnt), 32'(seq2[i]));
            chk("t2_co", 32'(co), (i == 0) ? 1 : 0);
        end

        // 3: load 13 together with a tick clamps to 9
        got = 0;
        for (int i = 0; i < 6 && !got; i++) begin
            step();
            if (tick) got = 1;
        end
        chk("t3_tick_seen", 32'(got), 1);
        load     = 1'b1;
        load_val = 4'd13;
        step();
        load = 1'b0;
        chk("t3_cnt", 32'(cnt), 9);
        chk("t3_co", 32'(co), 0);
        step();
        chk("t3_hold", 32'(cnt), 9);

        // 4: en=0 ignores five ticks
        en     = 1'b0;
        nt     = 0;
        any_co = 0;
        for (int i = 0; i < 40 && nt < 5; i++) begin
            step();
            if (tick) nt++;
            if (co) any_co = 1;
        end
        step();
        chk("t4_ticks", 32'(nt), 5);
        chk("t4_cnt", 32'(cnt), 9);
        chk("t4_co", 32'(any_co), 0);

        // 5: switch tap 0->3 while bit3 is high gives no tick
        free    = 1'b0;
        en      = 1'b1;
        up      = 1'b1;
        clk_div = '0;
        step();
        step();
        clk_div = 32'h8;
        tap_sel = 5'd3;
        step();
        chk("t5_switch", 32'(tick), 0);
        step();
        chk("t5_level", 32'(tick), 0);
        clk_div = '0;
        step();
        clk_div = 32'h8;
        step();
        chk("t5_rise", 32'(tick), 1);
        step();
        chk("t5_cnt", 32'(cnt), 0);
        chk("t5_co", 32'(co), 1);

        // 6: reset at cnt=7 with the tap high
        load     = 1'b1;
        load_val = 4'd7;
        step();
        load = 1'b0;
        chk("t6_load", 32'(cnt), 7);
        clk_div = '0;
        step();
        rst_n   = 1'b0;
        clk_div = 32'h8;
        step();
        rst_n = 1'b1;
        step();
        chk("t6_cnt", 32'(cnt), 0);
        chk("t6_tick", 32'(tick), 0);
        step();
        chk("t6_level", 32'(tick), 0);
        clk_div = '0;
        step();
        clk_div = 32'h8;
        step();
        chk("t6_rise", 32'(tick), 1);
        step();
        chk("t6_resume", 32'(cnt), 1);

        // 7: mixed traffic, checked by the model only
        free    = 1'b1;
        tap_sel = 5'd1;
        for (int i = 0; i < 90; i++) begin
            up       = ((i / 7) % 2) == 0;
            en       = (i % 11) != 3;
            load     = (i % 17) == 16;
            load_val = CNT_W'(i % 16);
            if (i == 40) tap_sel = 5'd31;
            if (i == 45) clk_div = 32'h7fff_fff0;
            if (i == 70) tap_sel = 5'd0;
            step();
        end
        load = 1'b0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
